// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core's MW-stage access (port C) and an
// external master (port E). Arbitration is round-robin, one access per cycle.
// The external master may take a bounded lock of up to LOCK_MAX consecutive
// grants for atomic sequences. The core is stalled whenever it is denied.
//
// Ports:
//   clk, reset                      clock; asynchronous active-low reset
//   core_rd_en/wr_en/addr/wdata     core request (MW stage)
//   core_rdata, core_stall          read data to the core; core was denied this cycle
//   ext_req/we/lock/addr/wdata      external request, held until granted
//   ext_gnt                         external access performed this cycle (combinational)
//   ext_rvalid, ext_rdata           registered read return, valid the cycle after a read grant
//   mem_addr/wdata/w_en/read_en     to the dmem
//   mem_rdata                       from the dmem (combinational read)
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LOCK_MAX   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd_en,
    input  logic                  core_wr_en,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic                  ext_lock,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_w_en,
    output logic                  mem_read_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {S_RR, S_LOCK} state_t;
    typedef enum logic {P_CORE, P_EXT} prio_t;

    state_t           state;
    prio_t            prio;
    logic [CNT_W-1:0] lock_cnt;

    logic core_req;
    logic core_gnt;
    logic owning;
    logic core_first;

    // Grant decision: a live lock excludes the core; otherwise round-robin,
    // with a forced core preference on the cycle a lock is released.
    always_comb begin
        core_req   = core_rd_en | core_wr_en;
        owning     = (state == S_LOCK) && ext_lock && (lock_cnt < CNT_W'(LOCK_MAX));
        core_first = (state == S_LOCK) || (prio == P_CORE);
        core_gnt   = 1'b0;
        ext_gnt    = 1'b0;
        if (owning) begin
            ext_gnt = ext_req;
        end else begin
            core_gnt = core_req && (!ext_req || core_first);
            ext_gnt  = ext_req && !core_gnt;
        end
        core_stall = core_req && !core_gnt;
    end

    // Memory-side mux; core values sit on addr/wdata when nobody is granted.
    always_comb begin
        mem_addr    = core_addr;
        mem_wdata   = core_wdata;
        mem_w_en    = 1'b0;
        mem_read_en = 1'b0;
        if (ext_gnt) begin
            mem_addr    = ext_addr;
            mem_wdata   = ext_wdata;
            mem_w_en    = ext_we;
            mem_read_en = !ext_we;
        end else if (core_gnt) begin
            mem_w_en    = core_wr_en;
            mem_read_en = core_rd_en;
        end
    end

    assign core_rdata = mem_rdata;

    // Arbitration state, lock counter and the external read-return register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_RR;
            prio       <= P_CORE;
            lock_cnt   <= '0;
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else begin
            ext_rvalid <= ext_gnt && !ext_we;
            if (ext_gnt && !ext_we) begin
                ext_rdata <= mem_rdata;
            end

            if (owning) begin
                if (ext_gnt) begin
                    lock_cnt <= lock_cnt + CNT_W'(1);
                end
            end else begin
                if (ext_gnt && ext_lock) begin
                    state    <= S_LOCK;
                    lock_cnt <= CNT_W'(1);
                end else begin
                    state    <= S_RR;
                    lock_cnt <= '0;
                end
                if (core_gnt) begin
                    prio <= P_EXT;
                end else if (ext_gnt) begin
                    prio <= P_CORE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all checked against a cycle-level ownership model.
module tb_dmem_arbiter;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned LMAX = 8;

    logic          clk;
    logic          reset;
    logic          core_rd_en, core_wr_en;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          ext_req, ext_we, ext_lock;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_w_en, mem_read_en;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .reset(reset),
        .core_rd_en(core_rd_en), .core_wr_en(core_wr_en),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_w_en(mem_w_en), .mem_read_en(mem_read_en),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: who owns the memory, how long the lock has run,
    // whose turn it is, and the pending read return.
    bit            m_locked;
    int            m_run;
    bit            m_core_turn;
    bit            m_rvalid;
    logic [DW-1:0] m_rdata;
    int            m_win;   // 0 none, 1 core, 2 ext

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked    = 1'b0;
        m_run       = 0;
        m_core_turn = 1'b1;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
    endtask

    // Settle the current inputs, decide the expected winner and compare every output.
    task automatic sample();
        bit creq;
        bit lock_live;
        #3;
        creq      = core_rd_en || core_wr_en;
        lock_live = m_locked && ext_lock && (m_run < LMAX);
        if (lock_live)                              m_win = ext_req ? 2 : 0;
        else if (creq && ext_req)                   m_win = (m_locked || m_core_turn) ? 1 : 2;
        else if (creq)                              m_win = 1;
        else if (ext_req)                           m_win = 2;
        else                                        m_win = 0;

        chk("ext_gnt",     32'(ext_gnt),    32'(m_win == 2));
        chk("core_stall",  32'(core_stall), 32'(creq && m_win != 1));
        chk("core_rdata",  core_rdata,      mem_rdata);
        chk("ext_rvalid",  32'(ext_rvalid), 32'(m_rvalid));
        chk("ext_rdata",   ext_rdata,       m_rdata);
        chk("mem_addr",    mem_addr,        (m_win == 2) ? ext_addr  : core_addr);
        chk("mem_wdata",   mem_wdata,       (m_win == 2) ? ext_wdata : core_wdata);
        chk("mem_w_en",    32'(mem_w_en),
            32'((m_win == 2 && ext_we) || (m_win == 1 && core_wr_en)));
        chk("mem_read_en", 32'(mem_read_en),
            32'((m_win == 2 && !ext_we) || (m_win == 1 && core_rd_en)));
    endtask

    // Advance one clock and update the model with the winner chosen in sample().
    task automatic tick();
        bit lock_live;
        @(posedge clk);
        lock_live = m_locked && ext_lock && (m_run < LMAX);
        m_rvalid  = (m_win == 2) && !ext_we;
        if (m_rvalid) m_rdata = mem_rdata;
        if (lock_live) begin
            if (m_win == 2) m_run++;
        end else begin
            if (m_win == 2 && ext_lock) begin
                m_locked = 1'b1;
                m_run    = 1;
            end else begin
                m_locked = 1'b0;
                m_run    = 0;
            end
            if (m_win == 1) m_core_turn = 1'b0;
            if (m_win == 2) m_core_turn = 1'b1;
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    // Asynchronous reset asserted mid-cycle, released just after a clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_rvalid", 32'(ext_rvalid), 32'(0));
        chk("rst_rdata",  ext_rdata,       32'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drive(input bit crd, input bit cwr, input bit ereq, input bit ewe, input bit elk);
        core_rd_en = crd;
        core_wr_en = cwr;
        ext_req    = ereq;
        ext_we     = ewe;
        ext_lock   = elk;
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        drive(0, 0, 0, 0, 0);
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        ext_addr   = 32'h0;
        ext_wdata  = 32'h0;
        mem_rdata  = 32'h0;
        model_reset();
        m_win      = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Idle after reset: no grants, no stall.
        sample();
        chk("idle_gnt",   32'(ext_gnt),    32'(0));
        chk("idle_stall", 32'(core_stall), 32'(0));
        tick();

        // Reset in the middle of a lock (three locked reads done).
        drive(0, 0, 1, 0, 1);
        ext_addr  = 32'h80;
        mem_rdata = 32'hCAFE0001;
        repeat (3) cycle();
        chk("prelock_rvalid", 32'(ext_rvalid), 32'(1));
        do_reset();
        drive(1, 0, 1, 0, 0);
        sample();
        chk("rstlock_core_wins", 32'(core_stall), 32'(0));
        chk("rstlock_ext_denied", 32'(ext_gnt),   32'(0));
        tick();

        // Core-only read.
        do_reset();
        drive(1, 0, 0, 0, 0);
        core_addr = 32'h10;
        mem_rdata = 32'hDEADBEEF;
        sample();
        chk("crd_read_en", 32'(mem_read_en), 32'(1));
        chk("crd_addr",    mem_addr,         32'h10);
        chk("crd_rdata",   core_rdata,       32'hDEADBEEF);
        chk("crd_stall",   32'(core_stall),  32'(0));
        chk("crd_egnt",    32'(ext_gnt),     32'(0));
        tick();

        // Both request continuously from reset: C, E, C, E.
        do_reset();
        drive(1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("alt_gnt",   32'(ext_gnt),    32'(i % 2));
            chk("alt_stall", 32'(core_stall), 32'(i % 2));
            tick();
        end

        // External read, core idle: rvalid pulse one cycle later.
        drive(0, 0, 1, 0, 0);
        ext_addr  = 32'h40;
        mem_rdata = 32'h12345678;
        sample();
        chk("erd_gnt",  32'(ext_gnt), 32'(1));
        chk("erd_addr", mem_addr,     32'h40);
        tick();
        drive(0, 0, 0, 0, 0);
        mem_rdata = 32'h0;
        sample();
        chk("erd_rvalid", 32'(ext_rvalid), 32'(1));
        chk("erd_rdata",  ext_rdata,       32'h12345678);
        tick();
        sample();
        chk("erd_rvalid_drop", 32'(ext_rvalid), 32'(0));
        chk("erd_rdata_hold",  ext_rdata,       32'h12345678);
        tick();

        // Lock with core waiting: LOCK_MAX ext grants, then the core.
        do_reset();
        drive(1, 0, 0, 0, 0);
        cycle();                       // core takes a turn, ext now has priority
        drive(1, 0, 1, 1, 1);
        ext_wdata = 32'hA5A5A5A5;
        n = 0;
        for (int i = 0; i <= LMAX; i++) begin
            sample();
            chk("lock_gnt", 32'(ext_gnt), 32'(i < LMAX));
            if (core_stall) n++;
            tick();
        end
        chk("lock_stall_cycles", 32'(n), 32'(LMAX));

        // Lock held through an ext idle gap: core still excluded, count preserved.
        do_reset();
        drive(0, 0, 1, 0, 1);
        cycle();                       // lock taken, one grant used
        drive(1, 0, 0, 0, 1);
        repeat (2) begin
            sample();
            chk("gap_gnt",   32'(ext_gnt),    32'(0));
            chk("gap_stall", 32'(core_stall), 32'(1));
            tick();
        end
        drive(1, 0, 1, 0, 1);
        for (int i = 0; i < LMAX; i++) begin
            sample();
            chk("gap_rest_gnt", 32'(ext_gnt), 32'(i < LMAX - 1));
            tick();
        end
        // Voluntary release: core wins as soon as ext_lock drops.
        do_reset();
        drive(0, 0, 1, 0, 1);
        repeat (2) cycle();
        drive(1, 0, 1, 0, 0);
        sample();
        chk("release_core", 32'(core_stall), 32'(0));
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            core_rd_en = ($urandom_range(0, 2) == 0);
            core_wr_en = ($urandom_range(0, 3) == 0);
            ext_req    = ($urandom_range(0, 1) == 0);
            ext_we     = $urandom_range(0, 1) == 1;
            ext_lock   = ($urandom_range(0, 3) != 0);
            core_addr  = $urandom;
            core_wdata = $urandom;
            ext_addr   = $urandom;
            ext_wdata  = $urandom;
            mem_rdata  = $urandom;
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
